lfsr_gen: RTL
=============

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 5, state width in bits; legal range 3..32.
REQ-002 Parameter MODE, default 0, feedback style: 0 = Fibonacci, 1 = Galois.
REQ-003 Parameter RESET_STATE, default 1 (WIDTH bits), state loaded by reset.
REQ-004 Parameter AUTO_RECOVER, default 1, enables automatic escape from the all-zero state.
REQ-005 clk  input  1  rising-edge clock, the only clock.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 reinit  input  1  synchronous load of initial_state.
REQ-008 advance  input  1  step the register once this cycle.
REQ-009 initial_state  input  WIDTH  seed for reinit.
REQ-010 taps  input  WIDTH  runtime feedback mask.
REQ-011 out  output  1  equals out_state[0].
REQ-012 out_state  output  WIDTH  current state register.
REQ-013 lockup  output  1  high while out_state is all-zero.
REQ-014 period_wrap  output  1  one-cycle pulse when the sequence returns to its reference state.
REQ-015 step_count  output  WIDTH  advances since the last reference-state capture.
REQ-016 last_period  output  WIDTH  length of the most recently completed period.

Function
REQ-017 Priority per cycle SHALL be: reinit, then advance, then hold.
REQ-018 reinit SHALL load state and ref_state with initial_state, clear step_count, and suppress period_wrap, regardless of advance.
REQ-019 Fibonacci advance SHALL compute next = {state[WIDTH-2:0], fb}, where fb = XOR-reduce(taps & state).
REQ-020 Galois advance SHALL compute next = (state << 1) ^ (state[WIDTH-1] ? taps : 0), truncated to WIDTH bits.
REQ-021 With AUTO_RECOVER=1, an advance from the all-zero state SHALL load 1 instead of the computed next state; with AUTO_RECOVER=0 the state remains zero.
REQ-022 Each advance SHALL increment step_count, saturating at all-ones.
REQ-023 When an advance produces next == ref_state, the block SHALL, in that same edge:
- set step_count to 0
- set last_period to step_count+1 (saturating)
- assert period_wrap for exactly the following cycle.
REQ-024 lockup SHALL be a registered-state decode (state == 0), with no extra latency beyond out_state.
REQ-025 A taps change SHALL take effect on the next advance; no state is flushed.
REQ-026 All outputs SHALL change only on a clk edge or on rst_n assertion.

Reset
REQ-027 While rst_n is low, the block SHALL set:
- state = RESET_STATE
- ref_state = RESET_STATE
- step_count = 0
- last_period = 0
- period_wrap = 0
REQ-028 Reset release SHALL be synchronised by the integrator; the first advance honoured is on the first edge with rst_n high.
REQ-029 Reset asserted mid-period SHALL discard the count without producing a period_wrap pulse.

Structure
REQ-030 The MODE encodings (LFSR_FIB = 0, LFSR_GAL = 1) SHALL live in the shared package lfsr_pkg.
REQ-031 The next-state computation SHALL be a combinational sub-module lfsr_next (WIDTH, MODE) with inputs state and taps and output next; the counters and ref_state logic SHALL stay in lfsr_gen.

Verification
REQ-032 WIDTH=5, Fibonacci, taps=5'b10100, reinit with 5'b00001, then 3 advances -> out_state = 5'b00010, 5'b00100, 5'b01001.
REQ-033 Same setup, 31 advances -> period_wrap pulses once after the 31st advance, last_period = 31, step_count = 0, out_state = 5'b00001.
REQ-034 Galois, taps=5'b10100, reinit with 5'b10000, then 2 advances -> 5'b10100, then 5'b11100.
REQ-035 reinit with 0 -> lockup = 1; one advance -> out_state = 5'b00001 and lockup = 0 (AUTO_RECOVER=1); out_state stays 0 with AUTO_RECOVER=0.
REQ-036 reinit and advance asserted in the same cycle -> out_state = initial_state and step_count = 0.
REQ-037 rst_n pulsed low mid-cycle after 10 advances -> out_state = 5'b00001 immediately (asynchronously), step_count = 0, no period_wrap.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator slice.
// Holds the feedback-style encodings used by lfsr_gen and lfsr_next.
package lfsr_pkg;

    typedef enum int {
        LFSR_FIB = 0,
        LFSR_GAL = 1
    } lfsr_mode_e;

    localparam int LFSR_MIN_W = 3;
    localparam int LFSR_MAX_W = 32;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between an LFSR generator and its user.
// master drives seed, taps and strobes; slave is the generator.
interface lfsr_gen_if #(
    parameter int WIDTH = 5
) ();

    logic             reinit;
    logic             advance;
    logic [WIDTH-1:0] initial_state;
    logic [WIDTH-1:0] taps;
    logic             out;
    logic [WIDTH-1:0] out_state;
    logic             lockup;
    logic             period_wrap;
    logic [WIDTH-1:0] step_count;
    logic [WIDTH-1:0] last_period;

    modport master (
        output reinit, advance, initial_state, taps,
        input  out, out_state, lockup, period_wrap,
        input  step_count, last_period
    );

    modport slave (
        input  reinit, advance, initial_state, taps,
        output out, out_state, lockup, period_wrap,
        output step_count, last_period
    );

endinterface

// File: rtl/lfsr_next.sv
// Combinational next-state function of the LFSR.
// Fibonacci shifts feedback in at bit 0; Galois XORs taps on MSB out.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next
);

    generate
        if (MODE == int'(LFSR_GAL)) begin : g_gal
            logic [WIDTH-1:0] w_mask;
            assign w_mask = state[WIDTH-1] ? taps : '0;
            // Galois: shift left, fold taps in when the MSB falls out
            always_comb begin
                next = {state[WIDTH-2:0], 1'b0} ^ w_mask;
            end
        end else begin : g_fib
            logic w_fb;
            assign w_fb = ^(taps & state);
            // Fibonacci: shift left, parity of tapped bits enters at LSB
            always_comb begin
                next = {state[WIDTH-2:0], w_fb};
            end
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Runtime-tapped LFSR with lock-up escape and period measurement.
// Period is counted against the state captured at reset or reinit.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 5,
    parameter int               MODE         = LFSR_FIB,
    parameter logic [WIDTH-1:0] RESET_STATE  = WIDTH'(1),
    parameter bit               AUTO_RECOVER = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    lfsr_gen_if.slave  bus
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_last;
    logic             r_wrap;

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_inc;
    logic             w_zero;
    logic             w_hit;

    lfsr_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_next (
        .state (r_state),
        .taps  (bus.taps),
        .next  (w_raw)
    );

    assign w_zero = (r_state == '0);
    assign w_hit  = (w_next == r_ref);

    // Escape the all-zero trap and saturate the step counter
    always_comb begin
        w_next = w_raw;
        if (AUTO_RECOVER && w_zero) begin
            w_next = WIDTH'(1);
        end
        w_inc = (r_count == '1) ? r_count : r_count + 1'b1;
    end

    // State, reference, counters and wrap pulse; reinit beats advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
            r_ref   <= RESET_STATE;
            r_count <= '0;
            r_last  <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.reinit) begin
            r_state <= bus.initial_state;
            r_ref   <= bus.initial_state;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.advance) begin
            r_state <= w_next;
            if (w_hit) begin
                r_count <= '0;
                r_last  <= w_inc;
                r_wrap  <= 1'b1;
            end else begin
                r_count <= w_inc;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.out         = r_state[0];
    assign bus.out_state   = r_state;
    assign bus.lockup      = w_zero;
    assign bus.period_wrap = r_wrap;
    assign bus.step_count  = r_count;
    assign bus.last_period = r_last;

endmodule
